// File: rtl/qdr_sched_pkg.sv
// rtl/qdr_sched_pkg.sv - shared types and widths for the QDR two-client command scheduler
package qdr_sched_pkg;

   localparam int CLIENT_W   = 1;
   localparam int QDR_ADDR_W = 22;
   localparam int QDR_DATA_W = 36;
   localparam int QDR_BE_W   = 4;

   typedef enum logic {
      WAIT_PHY = 1'b0,
      RUN      = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic                  we;
      logic [QDR_ADDR_W-1:0] addr;
      logic [QDR_DATA_W-1:0] wdata;
      logic [QDR_BE_W-1:0]   be;
   } sched_cmd_t;

endpackage

// File: rtl/qdr_cmd_scheduler_if.sv
// rtl/qdr_cmd_scheduler_if.sv - user-port bus between the scheduler and the QDR controller
// master = scheduler side, slave = controller side.
interface qdr_cmd_scheduler_if
   import qdr_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = QDR_ADDR_W,
   parameter int DATA_WIDTH = QDR_DATA_W,
   parameter int BE_WIDTH   = QDR_BE_W
);
   logic [ADDR_WIDTH-1:0] usr_addr;
   logic                  usr_wr_strb;
   logic [DATA_WIDTH-1:0] usr_wr_data;
   logic [BE_WIDTH-1:0]   usr_wr_be;
   logic                  usr_rd_strb;
   logic [DATA_WIDTH-1:0] usr_rd_data;
   logic                  usr_rd_dvld;

   modport master (
      output usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
      input  usr_rd_data, usr_rd_dvld
   );

   modport slave (
      input  usr_addr, usr_wr_strb, usr_wr_data, usr_wr_be, usr_rd_strb,
      output usr_rd_data, usr_rd_dvld
   );
endinterface

// File: rtl/qdr_sched_id_fifo.sv
// rtl/qdr_sched_id_fifo.sv - in-order FIFO of client IDs for outstanding reads
// Push and pop may coincide; a full FIFO accepts a push only alongside a pop.
module qdr_sched_id_fifo
   import qdr_sched_pkg::*;
#(
   parameter int DEPTH = 32
)(
   input  logic                  clk0,
   input  logic                  reset,
   input  logic                  push,
   input  logic [CLIENT_W-1:0]   push_id,
   input  logic                  pop,
   output logic [CLIENT_W-1:0]   head_id,
   output logic                  full,
   output logic                  empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [CLIENT_W-1:0] mem_q [DEPTH];
   logic [CLIENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   logic                do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != (PTR_W+1)'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_id;
      end
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry contents are don't-care while unoccupied, so storage is not reset.
   always_ff @(posedge clk0) begin
      mem_q <= mem_d;
   end

   assign head_id = mem_q[rd_ptr_q];
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/qdr_cmd_scheduler.sv
// rtl/qdr_cmd_scheduler.sv - round-robin two-client scheduler in front of the QDR user port
// Optional read watchdog is built when QDR_SCHED_TIMEOUT_EN is defined.
module qdr_cmd_scheduler
   import qdr_sched_pkg::*;
#(
   parameter int ADDR_WIDTH = QDR_ADDR_W,
   parameter int DATA_WIDTH = QDR_DATA_W,
   parameter int BE_WIDTH   = QDR_BE_W,
   parameter int ID_DEPTH   = 32
`ifdef QDR_SCHED_TIMEOUT_EN
   ,
   parameter int RD_TIMEOUT = 255
`endif
)(
   input  logic                       clk0,
   input  logic                       reset,
   input  logic                       phy_rdy,
   input  logic                       c0_req,
   input  logic                       c0_we,
   input  logic [ADDR_WIDTH-1:0]      c0_addr,
   input  logic [DATA_WIDTH-1:0]      c0_wdata,
   input  logic [BE_WIDTH-1:0]        c0_be,
   output logic                       c0_ack,
   output logic [DATA_WIDTH-1:0]      c0_rd_data,
   output logic                       c0_rd_dvld,
   input  logic                       c1_req,
   input  logic                       c1_we,
   input  logic [ADDR_WIDTH-1:0]      c1_addr,
   input  logic [DATA_WIDTH-1:0]      c1_wdata,
   input  logic [BE_WIDTH-1:0]        c1_be,
   output logic                       c1_ack,
   output logic [DATA_WIDTH-1:0]      c1_rd_data,
   output logic                       c1_rd_dvld,
   qdr_cmd_scheduler_if.master        usr,
   output logic [$clog2(ID_DEPTH):0]  rd_pending,
   output logic                       err_underflow,
   output logic                       err_timeout
);
   sched_state_e          state_q, state_d;
   logic [CLIENT_W-1:0]   rr_q, rr_d;
   logic [CLIENT_W-1:0]   grant_id, head_id;
   logic [1:0]            elig;
   logic                  grant_vld, push, pop, room;
   logic                  fifo_full, fifo_empty;
   logic [$clog2(ID_DEPTH):0] fifo_count;
   sched_cmd_t            cmd0, cmd1, cmd_sel;

   logic [ADDR_WIDTH-1:0] usr_addr_q, usr_addr_d;
   logic [DATA_WIDTH-1:0] usr_wr_data_q, usr_wr_data_d;
   logic [BE_WIDTH-1:0]   usr_wr_be_q, usr_wr_be_d;
   logic                  usr_wr_strb_q, usr_wr_strb_d;
   logic                  usr_rd_strb_q, usr_rd_strb_d;
   logic [DATA_WIDTH-1:0] c0_rd_data_q, c0_rd_data_d;
   logic [DATA_WIDTH-1:0] c1_rd_data_q, c1_rd_data_d;
   logic                  c0_rd_dvld_q, c0_rd_dvld_d;
   logic                  c1_rd_dvld_q, c1_rd_dvld_d;
   logic                  err_underflow_q, err_underflow_d;

   assign cmd0 = '{we: c0_we, addr: c0_addr, wdata: c0_wdata, be: c0_be};
   assign cmd1 = '{we: c1_we, addr: c1_addr, wdata: c1_wdata, be: c1_be};

   // A pop this cycle frees a slot, so a full FIFO can still take a read.
   always_comb begin
      pop       = usr.usr_rd_dvld & ~fifo_empty;
      room      = ~fifo_full | pop;
      elig[0]   = c0_req & (state_q == RUN) & (c0_we | room);
      elig[1]   = c1_req & (state_q == RUN) & (c1_we | room);
      grant_vld = |elig;
      grant_id  = (&elig) ? rr_q : elig[1];
      cmd_sel   = (grant_id == 1'b1) ? cmd1 : cmd0;
      push      = grant_vld & ~cmd_sel.we;
      c0_ack    = grant_vld & (grant_id == 1'b0);
      c1_ack    = grant_vld & (grant_id == 1'b1);
      rr_d      = grant_vld ? ~grant_id : rr_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WAIT_PHY: if (phy_rdy)  state_d = RUN;
         RUN:      if (!phy_rdy) state_d = WAIT_PHY;
         default:  state_d = WAIT_PHY;
      endcase

      usr_addr_d    = usr_addr_q;
      usr_wr_data_d = usr_wr_data_q;
      usr_wr_be_d   = usr_wr_be_q;
      if (grant_vld) begin
         usr_addr_d    = cmd_sel.addr;
         usr_wr_data_d = cmd_sel.wdata;
         usr_wr_be_d   = cmd_sel.be;
      end
      usr_wr_strb_d = grant_vld & cmd_sel.we;
      usr_rd_strb_d = push;

      c0_rd_dvld_d    = pop & (head_id == 1'b0);
      c1_rd_dvld_d    = pop & (head_id == 1'b1);
      c0_rd_data_d    = c0_rd_dvld_d ? usr.usr_rd_data : c0_rd_data_q;
      c1_rd_data_d    = c1_rd_dvld_d ? usr.usr_rd_data : c1_rd_data_q;
      err_underflow_d = err_underflow_q | (usr.usr_rd_dvld & fifo_empty);
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         state_q         <= WAIT_PHY;
         rr_q            <= '0;
         usr_addr_q      <= '0;
         usr_wr_data_q   <= '0;
         usr_wr_be_q     <= '0;
         usr_wr_strb_q   <= 1'b0;
         usr_rd_strb_q   <= 1'b0;
         c0_rd_data_q    <= '0;
         c1_rd_data_q    <= '0;
         c0_rd_dvld_q    <= 1'b0;
         c1_rd_dvld_q    <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         rr_q            <= rr_d;
         usr_addr_q      <= usr_addr_d;
         usr_wr_data_q   <= usr_wr_data_d;
         usr_wr_be_q     <= usr_wr_be_d;
         usr_wr_strb_q   <= usr_wr_strb_d;
         usr_rd_strb_q   <= usr_rd_strb_d;
         c0_rd_data_q    <= c0_rd_data_d;
         c1_rd_data_q    <= c1_rd_data_d;
         c0_rd_dvld_q    <= c0_rd_dvld_d;
         c1_rd_dvld_q    <= c1_rd_dvld_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   qdr_sched_id_fifo #(.DEPTH(ID_DEPTH)) u_id_fifo (
      .clk0    (clk0),
      .reset   (reset),
      .push    (push),
      .push_id (grant_id),
      .pop     (pop),
      .head_id (head_id),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

`ifdef QDR_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(RD_TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            err_timeout_q, err_timeout_d;

   // Counter saturates at the limit; the flag stays set until reset.
   always_comb begin
      to_cnt_d      = to_cnt_q;
      err_timeout_d = err_timeout_q;
      if (usr.usr_rd_dvld || (fifo_count == '0)) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TO_W'(RD_TIMEOUT)) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
      if (to_cnt_d == TO_W'(RD_TIMEOUT)) begin
         err_timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         to_cnt_q      <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif

   assign usr.usr_addr    = usr_addr_q;
   assign usr.usr_wr_data = usr_wr_data_q;
   assign usr.usr_wr_be   = usr_wr_be_q;
   assign usr.usr_wr_strb = usr_wr_strb_q;
   assign usr.usr_rd_strb = usr_rd_strb_q;
   assign c0_rd_data      = c0_rd_data_q;
   assign c1_rd_data      = c1_rd_data_q;
   assign c0_rd_dvld      = c0_rd_dvld_q;
   assign c1_rd_dvld      = c1_rd_dvld_q;
   assign rd_pending      = fifo_count;
   assign err_underflow   = err_underflow_q;

endmodule
